// File: rtl/bitstream_decoder_if.sv
// Serial-in / decoded-fields-out bundle for bitstream_decoder.
// master: bit source + packet consumer; slave: the decoder.
interface bitstream_decoder_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7,
  parameter int ENDP_W = 4
);
  logic              inb;
  logic              bit_valid;
  logic              line_active;
  logic [3:0]        pid;
  logic [ADDR_W-1:0] addr;
  logic [ENDP_W-1:0] endp;
  logic [DATA_W-1:0] data;
  logic              pkt_done;
  logic              pkt_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output inb, bit_valid, line_active,
    input  pid, addr, endp, data,
    input  pkt_done, pkt_err, err_code, busy
  );

  modport slave (
    input  inb, bit_valid, line_active,
    output pid, addr, endp, data,
    output pkt_done, pkt_err, err_code, busy
  );
endinterface

// File: rtl/bitstream_decoder.sv
// Serial packet decoder: SYNC hunt, PID/ADDR/ENDP/DATA fields LSB first.
// Ports: clk, rst (async high), bus (slave: inb/bit_valid/line_active in, fields+pulses out).
module bitstream_decoder #(
  parameter int         DATA_W   = 64,
  parameter int         ADDR_W   = 7,
  parameter int         ENDP_W   = 4,
  parameter logic [7:0] SYNC_PAT = 8'b1000_0000
) (
  input logic           clk,
  input logic           rst,
  bitstream_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_HUNT, S_PID, S_ADDR, S_ENDP, S_DATA
  } state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [6:0] PID_LAST  = 7'd7;
  localparam logic [6:0] ADDR_LAST = 7'(ADDR_W - 1);
  localparam logic [6:0] ENDP_LAST = 7'(ENDP_W - 1);
  localparam logic [6:0] DATA_LAST = 7'(DATA_W - 1);

  state_t            state_q, state_n;
  logic [7:0]        win_q, win_n;
  logic [DATA_W-1:0] sr_q, sr_n;
  logic [6:0]        cnt_q;
  logic [3:0]        pid_hold_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [3:0]        pid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ENDP_W-1:0] endp_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q, err_q;
  logic [1:0]        code_q;

  logic              acc, last, ok, err;
  logic [1:0]        code;
  logic [7:0]        pid_byte;
  logic [3:0]        pid_lo;

  // Fields fill the top of one shared register; after W shifts
  // the field sits in sr[DATA_W-1 -: W].
  assign acc      = bus.bit_valid & bus.line_active;
  assign win_n    = {bus.inb, win_q[7:1]};
  assign sr_n     = {bus.inb, sr_q[DATA_W-1:1]};
  assign pid_byte = sr_n[DATA_W-1 -: 8];
  assign pid_lo   = pid_byte[3:0];

  always_comb begin
    last = 1'b0;
    unique case (state_q)
      S_PID:   last = (cnt_q == PID_LAST);
      S_ADDR:  last = (cnt_q == ADDR_LAST);
      S_ENDP:  last = (cnt_q == ENDP_LAST);
      S_DATA:  last = (cnt_q == DATA_LAST);
      default: last = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HUNT;
    else     state_q <= state_n;
  end

  // next state and end-of-packet events
  always_comb begin
    state_n = state_q;
    ok      = 1'b0;
    err     = 1'b0;
    code    = 2'b00;
    if (state_q == S_HUNT) begin
      if (acc && win_n == SYNC_PAT) state_n = S_PID;
    end else if (!bus.line_active) begin
      // truncation wins over a bit arriving the same cycle
      err     = 1'b1;
      code    = 2'b11;
      state_n = S_HUNT;
    end else if (bus.bit_valid && last) begin
      unique case (state_q)
        S_PID: begin
          state_n = S_HUNT;
          if (pid_lo != ~pid_byte[7:4]) begin
            err  = 1'b1;
            code = 2'b01;
          end else begin
            unique case (1'b1)
              (pid_lo == PID_ACK) || (pid_lo == PID_NAK):
                ok = 1'b1;
              (pid_lo == PID_OUT) || (pid_lo == PID_IN):
                state_n = S_ADDR;
              (pid_lo == PID_DATA0):
                state_n = S_DATA;
              default: begin
                err  = 1'b1;
                code = 2'b10;
              end
            endcase
          end
        end
        S_ADDR: state_n = S_ENDP;
        S_ENDP: begin
          ok      = 1'b1;
          state_n = S_HUNT;
        end
        S_DATA: begin
          ok      = 1'b1;
          state_n = S_HUNT;
        end
        default: state_n = S_HUNT;
      endcase
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      pid_hold_q  <= '0;
      addr_hold_q <= '0;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      done_q <= ok;
      err_q  <= err;
      if (ok || err) code_q <= code;

      if (state_q != S_HUNT || !bus.line_active)
        win_q <= '0;
      else if (bus.bit_valid)
        win_q <= win_n;

      if (state_n != state_q) cnt_q <= '0;
      else if (acc)           cnt_q <= cnt_q + 7'd1;

      if (acc && state_q != S_HUNT) sr_q <= sr_n;

      if (acc && last && state_q == S_PID)
        pid_hold_q <= pid_lo;
      if (acc && last && state_q == S_ADDR)
        addr_hold_q <= sr_n[DATA_W-1 -: ADDR_W];

      if (ok) begin
        unique case (state_q)
          S_PID: pid_q <= pid_lo;
          S_ENDP: begin
            pid_q  <= pid_hold_q;
            addr_q <= addr_hold_q;
            endp_q <= sr_n[DATA_W-1 -: ENDP_W];
          end
          S_DATA: begin
            pid_q  <= pid_hold_q;
            data_q <= sr_n;
          end
          default: pid_q <= pid_q;
        endcase
      end
    end
  end

  // output drive
  always_comb begin
    bus.pid      = pid_q;
    bus.addr     = addr_q;
    bus.endp     = endp_q;
    bus.data     = data_q;
    bus.pkt_done = done_q;
    bus.pkt_err  = err_q;
    bus.err_code = code_q;
    bus.busy     = (state_q != S_HUNT);
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder.
// Drives on falling edge, samples on falling edge.
module tb_bitstream_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  int   err_cnt;

  bitstream_decoder_if bus ();

  bitstream_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    done_cnt = 0;
    err_cnt  = 0;
  end

  always @(negedge clk) begin
    if (bus.pkt_done === 1'b1) done_cnt++;
    if (bus.pkt_err === 1'b1)  err_cnt++;
  end

  // first bit sent is v[n-1] (stream order as written)
  task automatic send_msb(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.inb       = v[i];
      bus.bit_valid = 1'b1;
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
  endtask

  // first bit sent is v[0]; optional idle cycle between bits
  task automatic send_lsb(input logic [63:0] v, input int n,
                          input bit gap);
    for (int i = 0; i < n; i++) begin
      bus.inb       = v[i];
      bus.bit_valid = 1'b1;
      @(negedge clk);
      if (gap && i != n - 1) begin
        bus.bit_valid = 1'b0;
        bus.inb       = ~v[i];
        @(negedge clk);
      end
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_sync();
    send_msb(64'b0000_0001, 8);
  endtask

  task automatic test_reset();
    bus.inb         = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.line_active = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pid, bus.addr, bus.endp, bus.err_code} !== 17'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h/%h/%h/%b want 0",
               bus.pid, bus.addr, bus.endp, bus.err_code);
    end
    checks++;
    if ({bus.data, bus.pkt_done, bus.pkt_err, bus.busy} !== 67'h0) begin
      errors++;
      $display("FAIL reset_misc: data %h done %b err %b busy %b want 0",
               bus.data, bus.pkt_done, bus.pkt_err, bus.busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out();
    int base;
    base = done_cnt;
    bus.line_active = 1'b1;
    send_sync();
    send_msb(64'b1000_0111, 8);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL out_busy: got %b want 1", bus.busy);
    end
    send_msb(64'b1011011, 7);
    send_msb(64'b1011, 4);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL out_done: done %b err %b want 1 0",
               bus.pkt_done, bus.pkt_err);
    end
    checks++;
    if (bus.pid !== 4'b0001 || bus.addr !== 7'h6D ||
        bus.endp !== 4'hD || bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL out_fields: got %b %h %h %b want 0001 6d d 00",
               bus.pid, bus.addr, bus.endp, bus.err_code);
    end
    @(negedge clk);
    checks++;
    if (bus.pkt_done !== 1'b0 || done_cnt - base !== 1) begin
      errors++;
      $display("FAIL out_pulse: done %b count %0d want 0 1",
               bus.pkt_done, done_cnt - base);
    end
  endtask

  task automatic test_data0();
    int base;
    base = done_cnt;
    send_sync();
    send_lsb(64'hC3, 8, 1'b1);
    send_lsb(64'h0123_4567_89AB_CDEF, 64, 1'b1);
    checks++;
    if (bus.pkt_done !== 1'b1 || done_cnt - base !== 0) begin
      errors++;
      $display("FAIL data_done: done %b early %0d want 1 0",
               bus.pkt_done, done_cnt - base);
    end
    checks++;
    if (bus.data !== 64'h0123_4567_89AB_CDEF || bus.pid !== 4'b0011) begin
      errors++;
      $display("FAIL data_fields: got %h %b want 0123456789abcdef 0011",
               bus.data, bus.pid);
    end
    checks++;
    if (bus.addr !== 7'h6D || bus.endp !== 4'hD) begin
      errors++;
      $display("FAIL data_keep: got %h %h want 6d d",
               bus.addr, bus.endp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cnt;
    send_sync();
    send_msb(64'b0100_1011, 8);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.pid !== 4'b0010) begin
      errors++;
      $display("FAIL ack: done %b pid %b want 1 0010",
               bus.pkt_done, bus.pid);
    end
    send_sync();
    send_lsb(64'h5A, 8, 1'b0);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.pid !== 4'b1010) begin
      errors++;
      $display("FAIL nak: done %b pid %b want 1 1010",
               bus.pkt_done, bus.pid);
    end
    checks++;
    if (bus.addr !== 7'h6D || bus.endp !== 4'hD ||
        bus.data !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL b2b_keep: got %h %h %h", bus.addr, bus.endp, bus.data);
    end
    @(negedge clk);
    checks++;
    if (done_cnt - base !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", done_cnt - base);
    end
  endtask

  task automatic test_pid_errors();
    send_sync();
    send_msb(64'b1000_1111, 8);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'b01 ||
        bus.busy !== 1'b0 || bus.pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL pid_check: err %b code %b busy %b done %b want 1 01 0 0",
               bus.pkt_err, bus.err_code, bus.busy, bus.pkt_done);
    end
    checks++;
    if (bus.pid !== 4'b1010) begin
      errors++;
      $display("FAIL pid_check_keep: got %b want 1010", bus.pid);
    end
    @(negedge clk);
    checks++;
    if (bus.pkt_err !== 1'b0 || bus.err_code !== 2'b01) begin
      errors++;
      $display("FAIL pid_err_hold: err %b code %b want 0 01",
               bus.pkt_err, bus.err_code);
    end
    send_sync();
    send_msb(64'b0000_1111, 8);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'b10) begin
      errors++;
      $display("FAIL pid_unknown: err %b code %b want 1 10",
               bus.pkt_err, bus.err_code);
    end
    @(negedge clk);
  endtask

  task automatic test_truncation();
    send_sync();
    send_msb(64'b1000_0111, 8);
    send_msb(64'b101, 3);
    bus.line_active = 1'b0;
    bus.bit_valid   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'b11 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL trunc: err %b code %b busy %b want 1 11 0",
               bus.pkt_err, bus.err_code, bus.busy);
    end
    checks++;
    if (bus.pid !== 4'b1010 || bus.addr !== 7'h6D || bus.endp !== 4'hD) begin
      errors++;
      $display("FAIL trunc_keep: got %b %h %h want 1010 6d d",
               bus.pid, bus.addr, bus.endp);
    end
    bus.bit_valid   = 1'b0;
    bus.line_active = 1'b1;
    @(negedge clk);
    send_sync();
    send_msb(64'b1000_0111, 8);
    send_lsb(64'h2A, 7, 1'b0);
    send_lsb(64'h3, 4, 1'b0);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.pid !== 4'b0001 ||
        bus.addr !== 7'h2A || bus.endp !== 4'h3 ||
        bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL trunc_next: done %b %b %h %h %b want 1 0001 2a 3 00",
               bus.pkt_done, bus.pid, bus.addr, bus.endp, bus.err_code);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    send_sync();
    send_lsb(64'hC3, 8, 1'b0);
    send_lsb(64'hFFFF_F, 20, 1'b0);
    base = err_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pid !== 4'h0 || bus.addr !== 7'h0 || bus.endp !== 4'h0 ||
        bus.data !== 64'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: %b %h %h %h busy %b want all 0",
               bus.pid, bus.addr, bus.endp, bus.data, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pkt_err !== 1'b0 || err_cnt - base !== 0) begin
      errors++;
      $display("FAIL rst_no_err: err %b count %0d want 0 0",
               bus.pkt_err, err_cnt - base);
    end
    send_sync();
    send_msb(64'b1000_0111, 8);
    send_msb(64'b1011011, 7);
    send_msb(64'b1011, 4);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.pid !== 4'b0001 ||
        bus.addr !== 7'h6D || bus.endp !== 4'hD || bus.data !== 64'h0) begin
      errors++;
      $display("FAIL rst_next: done %b %b %h %h %h want 1 0001 6d d 0",
               bus.pkt_done, bus.pid, bus.addr, bus.endp, bus.data);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_out();
    test_data0();
    test_back_to_back();
    test_pid_errors();
    test_truncation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
Name: bitstream_decoder

Overview:
Serial receive end of the packet link. Recovers SYNC, PID, ADDR/ENDP or DATA fields from the 1-bit stream produced by the bitstream encoder and presents them as parallel registered fields with a one-cycle done/error pulse. Sits after the serial line and before the protocol FSM, which consumes decoded packets.

Parameters:
DATA_W, 64, data payload width in bits
ADDR_W, 7, address field width
ENDP_W, 4, endpoint field width
SYNC_PAT, 8'b1000_0000, SYNC value as assembled LSB-first

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inb  in  1  serial data bit
bit_valid  in  1  inb is a new bit this cycle (low = pause, hold)
line_active  in  1  transmitter is driving a packet (encoder's sending)
pid  out  4  decoded PID
addr  out  ADDR_W  decoded address (OUT/IN)
endp  out  ENDP_W  decoded endpoint (OUT/IN)
data  out  DATA_W  decoded payload (DATA0)
pkt_done  out  1  one-cycle pulse: fields valid, packet good
pkt_err  out  1  one-cycle pulse: packet dropped
err_code  out  2  01 PID check fail, 10 unknown PID, 11 truncated; held until next pkt_done/pkt_err
busy  out  1  high in any state other than HUNT

Behaviour:
- One clock domain, clk; rst asynchronous, active-high. On rst: state HUNT, all outputs, shift registers and counter to 0.
- Bit ordering: every field LSB first; new bit shifts into MSB of the field shift register. PID field is 8 bits: pid[3:0] followed by ~pid[3:0].
- A bit is accepted only on a clk edge with bit_valid=1 and line_active=1. bit_valid=0 freezes state, counter, shift registers.
- PID values: OUT 0001, IN 1001, DATA0 0011, ACK 0010, NAK 1010.
- States:
  HUNT: 8-bit sliding window; accepted bits shift in. Window cleared while line_active=0. On accept making window == SYNC_PAT -> PID, counter cleared.
  PID: collect 8 bits. On 8th: if low nibble != ~high nibble -> pkt_err, err_code 01, HUNT. Else if ACK/NAK -> pid updated, pkt_done, HUNT. OUT/IN -> ADDR. DATA0 -> DATA. Any other nibble -> pkt_err, err_code 10, HUNT.
  ADDR: collect ADDR_W bits -> ENDP.
  ENDP: collect ENDP_W bits -> pid/addr/endp updated, pkt_done, HUNT.
  DATA: collect DATA_W bits -> pid/data updated, pkt_done, HUNT.
- Bit counter: 7 bits, cleared on each field entry, increments per accepted bit; field ends when count == width-1 on an accept.
- Output fields update on the edge that accepts the final bit; pkt_done/pkt_err high for exactly the following cycle. Unused fields (addr/endp for DATA0/ACK/NAK, data for OUT/IN/ACK/NAK) keep previous values.
- pid/addr/endp/data never change on error.
- Truncation: line_active=0 in PID/ADDR/ENDP/DATA -> pkt_err, err_code 11, HUNT next cycle; takes priority over a simultaneous bit_valid.
- Return to HUNT clears the window; every packet needs a full SYNC. Back-to-back packets need no idle cycles.
- rst mid-packet: immediate abort, no pkt_err pulse.
- busy = (state != HUNT).

Test Plan:
- OUT: line_active=1, bits 0000_0001 | 1000 0111 | 1011011 | 1011, bit_valid=1 each cycle -> pkt_done one cycle after 27th bit; pid=0001, addr=7'h6D, endp=4'hD, err_code=00.
- DATA0 data=64'h0123_4567_89AB_CDEF with bit_valid toggling 1/0 -> pkt_done after 80 accepted bits, data matches exactly, no early pulse.
- ACK (PID bits 0100 1011) then immediately NAK sync+PID -> two pkt_done pulses, pid 0010 then 1010, addr/endp unchanged.
- PID bits 1000 1111 (check fail) -> pkt_err, err_code=01, busy=0 next cycle; 0000 1111 -> err_code=10.
- line_active drops after 3 ADDR bits -> pkt_err, err_code=11, fields unchanged; next full OUT decodes correctly.
- rst asserted mid-DATA -> all outputs 0 asynchronously, no pkt_err; post-reset packet decodes.
